imem_prog_store: RTL and testbench

//  Writable, multi-program instruction memory; successor to the fixed-case ROM. Host streams

---
 rtl/imem_prog_store_if.sv | 31 +++
 rtl/imem_prog_store.sv | 125 ++++++++++++
 tb/tb_imem_prog_store.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_prog_store_if.sv
// rtl/imem_prog_store_if.sv - loader, clear and fetch bus for the program store
interface imem_prog_store_if #(
  parameter int INST_W = 9,
  parameter int PC_W   = 8,
  parameter int SEL_W  = 2
);
  logic              clr;
  logic              ld_start;
  logic [SEL_W-1:0]  ld_slot;
  logic              ld_valid;
  logic [INST_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_err;
  logic              fetch_en;
  logic [SEL_W-1:0]  prog_sel;
  logic [PC_W-1:0]   PC;
  logic              fetch_rdy;
  logic [INST_W-1:0] inst;
  logic              inst_vld;

  modport master (
    output clr, ld_start, ld_slot, ld_valid, ld_data, ld_last, fetch_en, prog_sel, PC,
    input  ld_ready, ld_err, fetch_rdy, inst, inst_vld
  );

  modport slave (
    input  clr, ld_start, ld_slot, ld_valid, ld_data, ld_last, fetch_en, prog_sel, PC,
    output ld_ready, ld_err, fetch_rdy, inst, inst_vld
  );
endinterface

// File: rtl/imem_prog_store.sv
// rtl/imem_prog_store.sv - writable multi-slot instruction memory with streaming loader
module imem_prog_store #(
  parameter int                INST_W  = 9,
  parameter int                PC_W    = 8,
  parameter int                ADDR_W  = 8,
  parameter int                NPROG   = 4,
  parameter logic [INST_W-1:0] HALT_OP = '1
) (
  input logic              CLK,
  input logic              reset_n,
  imem_prog_store_if.slave bus
);
  localparam int SEL_W = (NPROG > 1) ? $clog2(NPROG) : 1;

  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [INST_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W:0]   fill_ptr;
  logic [NPROG-1:0]  slot_vld;
  logic [ADDR_W-1:0] base [NPROG];
  logic [PC_W:0]     len  [NPROG];
  logic [SEL_W-1:0]  cur_slot;

  logic              full;
  logic              beat;
  logic              len_sat;
  logic              mem_we;
  logic              fetch_hit;
  logic [ADDR_W-1:0] fetch_addr;

  // fill_ptr carries one extra bit so "array full" is distinguishable from address 0
  assign full       = fill_ptr[ADDR_W];
  assign beat       = bus.ld_valid && bus.ld_ready;
  assign len_sat    = len[cur_slot][PC_W];
  assign mem_we     = beat && !len_sat && !bus.clr;
  assign fetch_addr = base[bus.prog_sel] + ADDR_W'(bus.PC);
  assign fetch_hit  = slot_vld[bus.prog_sel] && ({1'b0, bus.PC} < len[bus.prog_sel]);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.ld_start) state_nxt = LOAD;
        LOAD: begin
          if (beat && bus.ld_last)          state_nxt = IDLE;
          else if (bus.ld_valid && full)    state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ld_ready  = 1'b0;
    bus.fetch_rdy = 1'b0;
    case (state)
      IDLE:    bus.fetch_rdy = 1'b1;
      LOAD:    bus.ld_ready  = !full;
      default: bus.fetch_rdy = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      fill_ptr     <= '0;
      slot_vld     <= '0;
      cur_slot     <= '0;
      bus.ld_err   <= 1'b0;
      bus.inst     <= HALT_OP;
      bus.inst_vld <= 1'b0;
      for (int i = 0; i < NPROG; i++) begin
        base[i] <= '0;
        len[i]  <= '0;
      end
    end else if (bus.clr) begin
      fill_ptr     <= '0;
      slot_vld     <= '0;
      bus.inst_vld <= 1'b0;
    end else begin
      bus.inst_vld <= 1'b0;
      case (state)
        IDLE: begin
          // a fetch issued alongside ld_start sees the slot table before it is cleared
          if (bus.fetch_en) begin
            bus.inst_vld <= 1'b1;
            bus.inst     <= fetch_hit ? mem[fetch_addr] : HALT_OP;
          end
          if (bus.ld_start) begin
            cur_slot               <= bus.ld_slot;
            slot_vld[bus.ld_slot]  <= 1'b0;
            base[bus.ld_slot]      <= fill_ptr[ADDR_W-1:0];
            len[bus.ld_slot]       <= '0;
          end
        end
        LOAD: begin
          if (beat) begin
            if (!len_sat) begin
              fill_ptr       <= fill_ptr + 1'b1;
              len[cur_slot]  <= len[cur_slot] + 1'b1;
            end
            if (bus.ld_last) slot_vld[cur_slot] <= 1'b1;
          end else if (bus.ld_valid && full) begin
            bus.ld_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[fill_ptr[ADDR_W-1:0]] <= bus.ld_data;
  end
endmodule

// File: tb/tb_imem_prog_store.sv
// tb/tb_imem_prog_store.sv - randomized bench against a per-program content model
module tb_imem_prog_store;
  localparam logic [8:0] HALT = 9'h1FF;

  logic CLK;
  logic reset_n;

  imem_prog_store_if #(.INST_W(9), .PC_W(8), .SEL_W(2)) bus ();

  imem_prog_store #(
    .INST_W(9), .PC_W(8), .ADDR_W(8), .NPROG(4), .HALT_OP(HALT)
  ) dut (
    .CLK(CLK),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  // model: each slot is just its word list; storage is a single usage count
  logic [8:0] pw [4][256];
  int         plen [4];
  bit         pok [4];
  bit         m_loading;
  int         m_cur;
  int         m_used;
  logic [8:0] e_inst;
  logic       e_vld;
  logic       e_err;
  logic [8:0] wbuf [300];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loading = 0;
    m_used    = 0;
    m_cur     = 0;
    for (int s = 0; s < 4; s++) begin
      pok[s]  = 0;
      plen[s] = 0;
    end
    e_inst = HALT;
    e_vld  = 0;
    e_err  = 0;
  endtask

  task automatic model_step();
    int sel;
    int pc;
    sel = int'(bus.prog_sel);
    pc  = int'(bus.PC);
    if (bus.clr) begin
      m_loading = 0;
      m_used    = 0;
      for (int s = 0; s < 4; s++) pok[s] = 0;
      e_vld = 0;
    end else if (!m_loading) begin
      e_vld = bus.fetch_en;
      if (bus.fetch_en) e_inst = (pok[sel] && pc < plen[sel]) ? pw[sel][pc] : HALT;
      if (bus.ld_start) begin
        m_loading   = 1;
        m_cur       = int'(bus.ld_slot);
        pok[m_cur]  = 0;
        plen[m_cur] = 0;
      end
    end else begin
      e_vld = 0;
      if (bus.ld_valid) begin
        if (m_used < 256) begin
          if (plen[m_cur] < 256) begin
            pw[m_cur][plen[m_cur]] = bus.ld_data;
            plen[m_cur]++;
            m_used++;
          end
          if (bus.ld_last) begin
            pok[m_cur] = 1;
            m_loading  = 0;
          end
        end else begin
          e_err     = 1;
          m_loading = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    if (!reset_n) model_reset();
    else          model_step();
    #1;
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("ld_ready",  {31'd0, bus.ld_ready},  {31'd0, m_loading && m_used < 256});
      check("fetch_rdy", {31'd0, bus.fetch_rdy}, {31'd0, !m_loading});
      check("inst_vld",  {31'd0, bus.inst_vld},  {31'd0, e_vld});
      check("ld_err",    {31'd0, bus.ld_err},    {31'd0, e_err});
      check("inst",      {23'd0, bus.inst},      {23'd0, e_inst});
    end
  end

  task automatic set_idle();
    bus.clr      = 0;
    bus.ld_start = 0;
    bus.ld_slot  = '0;
    bus.ld_valid = 0;
    bus.ld_data  = '0;
    bus.ld_last  = 0;
    bus.fetch_en = 0;
    bus.prog_sel = '0;
    bus.PC       = '0;
  endtask

  task automatic pin(input string name, input logic [8:0] lit);
    check({name, "_model"}, {23'd0, e_inst}, {23'd0, lit});
    check(name, {23'd0, bus.inst}, {23'd0, lit});
    check({name, "_vld"}, {31'd0, bus.inst_vld}, 32'd1);
  endtask

  task automatic fetch(input int sel, input int pc);
    set_idle();
    bus.fetch_en = 1;
    bus.prog_sel = 2'(sel);
    bus.PC       = 8'(pc);
    tick();
    set_idle();
  endtask

  task automatic stream(input int n, input bit gaps, input bit with_last);
    int  idx;
    int  budget;
    bit  v;
    bit  acc;
    idx    = 0;
    budget = 0;
    while (m_loading && budget < 2000) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.ld_valid = v;
      bus.ld_data  = wbuf[idx];
      bus.ld_last  = with_last && (idx == n - 1);
      bus.fetch_en = $urandom_range(0, 1) == 1;
      bus.prog_sel = 2'($urandom_range(0, 3));
      bus.PC       = 8'($urandom_range(0, 5));
      acc = v && m_used < 256;
      tick();
      if (acc && idx < 299) idx++;
      budget++;
    end
    if (budget >= 2000) check("load_timeout", 32'd0, 32'd1);
    set_idle();
  endtask

  task automatic load_prog(input int slot, input int n, input bit gaps, input bit with_last);
    set_idle();
    bus.ld_start = 1;
    bus.ld_slot  = 2'(slot);
    tick();
    set_idle();
    stream(n, gaps, with_last);
  endtask

  task automatic load_rand(input int slot, input int n);
    for (int i = 0; i < n; i++) wbuf[i] = 9'($urandom);
    load_prog(slot, n, 1'b1, 1'b1);
  endtask

  initial begin
    reset_n = 0;
    set_idle();
    model_reset();
    tick();
    chk_en = 1;
    check("rst_ld_ready",  {31'd0, bus.ld_ready},  32'd0);
    check("rst_fetch_rdy", {31'd0, bus.fetch_rdy}, 32'd1);
    check("rst_inst",      {23'd0, bus.inst},      {23'd0, HALT});
    check("rst_inst_vld",  {31'd0, bus.inst_vld},  32'd0);
    check("rst_ld_err",    {31'd0, bus.ld_err},    32'd0);
    reset_n = 1;
    tick();

    wbuf[0] = 9'h100; wbuf[1] = 9'h16B; wbuf[2] = 9'h1FF;
    load_prog(0, 3, 1'b1, 1'b1);
    fetch(0, 0); pin("s0_pc0", 9'h100);
    fetch(0, 1); pin("s0_pc1", 9'h16B);
    fetch(0, 2); pin("s0_pc2", 9'h1FF);

    wbuf[0] = 9'h0A0; wbuf[1] = 9'h0A1; wbuf[2] = 9'h0A2; wbuf[3] = 9'h0A3;
    load_prog(1, 4, 1'b1, 1'b1);
    fetch(1, 1); pin("s1_pc1", 9'h0A1);
    fetch(1, 3); pin("s1_pc3", 9'h0A3);
    fetch(0, 3); pin("s0_pc3_halt", HALT);
    fetch(2, 0); pin("s2_unloaded", HALT);

    set_idle();
    bus.ld_start = 1;
    bus.ld_slot  = 2'd3;
    bus.fetch_en = 1;
    bus.prog_sel = 2'd0;
    bus.PC       = 8'd1;
    tick();
    set_idle();
    pin("start_fetch", 9'h16B);
    check("start_fetch_rdy", {31'd0, bus.fetch_rdy}, 32'd0);
    wbuf[0] = 9'h033; wbuf[1] = 9'h044; wbuf[2] = 9'h055;
    stream(3, 1'b1, 1'b1);
    fetch(3, 2); pin("s3_pc2", 9'h055);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) load_rand($urandom_range(0, 3), $urandom_range(1, 8));
      else fetch($urandom_range(0, 3), $urandom_range(0, 9));
    end

    set_idle();
    bus.clr = 1;
    tick();
    set_idle();
    for (int s = 0; s < 4; s++) begin
      fetch(s, 0);
      pin("clr_halt", HALT);
    end
    wbuf[0] = 9'h011; wbuf[1] = 9'h022;
    load_prog(0, 2, 1'b0, 1'b1);
    fetch(0, 1); pin("after_clr", 9'h022);

    set_idle();
    bus.clr = 1;
    tick();
    set_idle();
    for (int i = 0; i < 257; i++) wbuf[i] = 9'(i * 7);
    load_prog(2, 257, 1'b0, 1'b0);
    check("fill_err_model", {31'd0, e_err},        32'd1);
    check("fill_err",       {31'd0, bus.ld_err},   32'd1);
    check("fill_idle",      {31'd0, bus.fetch_rdy}, 32'd1);
    fetch(2, 0); pin("fill_invalid", HALT);

    set_idle();
    bus.ld_start = 1;
    bus.ld_slot  = 2'd1;
    tick();
    set_idle();
    bus.ld_valid = 1;
    bus.ld_data  = 9'h0AA;
    tick();
    reset_n = 0;
    model_reset();
    set_idle();
    tick();
    tick();
    check("midrst_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
    check("midrst_ld_err",   {31'd0, bus.ld_err},   32'd0);
    check("midrst_inst",     {23'd0, bus.inst},     {23'd0, HALT});
    reset_n = 1;
    tick();
    for (int s = 0; s < 4; s++) begin
      fetch(s, 0);
      pin("rst_halt", HALT);
    end
    wbuf[0] = 9'h0C1;
    load_prog(1, 1, 1'b0, 1'b1);
    fetch(1, 0); pin("after_rst", 9'h0C1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
